// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, registered instr/pc toward IF/ID.
// Latency: one cycle from imem_ack to instr_out; stall parks one response in a hold register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump,
    input  logic        jump_mem,
    input  logic        BrZ,
    input  logic        BrN,
    input  logic        Z,
    input  logic        N,
    input  logic [31:0] br_target,
    input  logic [31:0] mem_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic        flush_out,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        redirect;
    logic [31:0] target;

    assign redirect  = jump | jump_mem | (BrZ & Z) | (BrN & N);
    assign target    = jump_mem ? mem_target : br_target;
    assign flush_out = redirect;
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            hold_instr  <= 32'h0;
            hold_pc     <= 32'h0;
            instr_out   <= NOP_INSTR;
            pc_out      <= 32'h0;
            valid_out   <= 1'b0;
            fetch_count <= 16'h0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        pc        <= target;
                        valid_out <= 1'b0;
                        instr_out <= NOP_INSTR;
                        // An unanswered request must be drained before refetching.
                        state     <= imem_ack ? FETCH : DRAIN;
                    end else if (imem_ack) begin
                        pc <= pc + 32'd1;
                        if (!stall) begin
                            instr_out   <= imem_rdata;
                            pc_out      <= pc;
                            valid_out   <= 1'b1;
                            fetch_count <= fetch_count + 16'd1;
                        end else begin
                            hold_instr <= imem_rdata;
                            hold_pc    <= pc;
                            state      <= HOLD;
                        end
                    end else if (!stall) begin
                        valid_out <= 1'b0;
                        instr_out <= NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc        <= target;
                        valid_out <= 1'b0;
                        instr_out <= NOP_INSTR;
                        state     <= FETCH;
                    end else if (!stall) begin
                        instr_out   <= hold_instr;
                        pc_out      <= hold_pc;
                        valid_out   <= 1'b1;
                        fetch_count <= fetch_count + 16'd1;
                        state       <= FETCH;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        pc        <= target;
                        valid_out <= 1'b0;
                        instr_out <= NOP_INSTR;
                    end
                    if (imem_ack) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0000, instruction word driven whenever instr_out is not valid.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: stall  input  1  hazard unit hold request; freezes the IF/ID-facing outputs.
REQ-006 Port: jump, jump_mem, BrZ, BrN  input  1 each  MEM-stage control bits from the EX/MEM buffer.
REQ-007 Port: Z, N  input  1 each  MEM-stage flags from the EX/MEM buffer.
REQ-008 Port: br_target  input  32  redirect target for jump/BrZ/BrN; mem_target  input  32  target for jump_mem (data-memory read).
REQ-009 Port: imem_req  output  1  instruction-memory request; imem_addr  output  32  request address.
REQ-010 Port: imem_ack  input  1  one-cycle response strobe; imem_rdata  input  32  instruction, valid when imem_ack=1.
REQ-011 Port: instr_out, pc_out  output  32 each  registered instruction and its PC, feeding ifid_buf.
REQ-012 Port: valid_out  output  1  instr_out/pc_out hold a real instruction.
REQ-013 Port: flush_out  output  1  combinational; equals redirect, squashes younger stages.
REQ-014 Port: fetch_count  output  16  count of instructions delivered.

Function
REQ-015 redirect = jump | jump_mem | (BrZ & Z) | (BrN & N); target = mem_target if jump_mem else br_target.
REQ-016 States: FETCH, HOLD, DRAIN; internal pc register; internal hold register (32-bit instr + 32-bit pc).
REQ-017 FETCH: imem_req=1, imem_addr=pc; HOLD and DRAIN: imem_req=0.
REQ-018 FETCH, ack=1, no redirect, stall=0: instr_out<=imem_rdata, pc_out<=pc, valid_out<=1, pc<=pc+1, fetch_count+=1, stay FETCH.
REQ-019 FETCH, ack=1, no redirect, stall=1: hold<=(imem_rdata, pc), pc<=pc+1, outputs unchanged, go HOLD.
REQ-020 FETCH, ack=0, no redirect: if stall=0, valid_out<=0 and instr_out<=NOP_INSTR; if stall=1, outputs unchanged.
REQ-021 HOLD, stall=0, no redirect: outputs<=hold, valid_out<=1, fetch_count+=1, go FETCH; stall=1: remain HOLD, outputs unchanged.
REQ-022 Redirect takes priority over stall and ack: pc<=target, valid_out<=0, instr_out<=NOP_INSTR, pc_out unchanged.
REQ-023 Redirect in FETCH with ack=1, or in HOLD: discard response/hold, next state FETCH.
REQ-024 Redirect in FETCH with ack=0: next state DRAIN (one outstanding request).
REQ-025 DRAIN: wait for imem_ack, discard imem_rdata, then FETCH; further redirects in DRAIN update pc, stay DRAIN.
REQ-026 pc+1 wraps 32'hFFFF_FFFF -> 32'h0; fetch_count wraps 16'hFFFF -> 0.
REQ-027 At most one outstanding imem request; imem_addr stable while imem_req=1 and ack not received.

Reset
REQ-028 rst=1 immediately forces: pc=RESET_PC, state=FETCH, valid_out=0, instr_out=NOP_INSTR, pc_out=0, hold=0, fetch_count=0.
REQ-029 Reset mid-request: the outstanding response is ignored; first post-reset cycle issues imem_req at RESET_PC.

Verification
REQ-030 Reset release, imem_ack every cycle, rdata=addr+32'h100 -> pc_out 0,1,2,... with instr_out 0x100,0x101,..., valid_out=1, fetch_count increments each cycle.
REQ-031 stall=1 for 3 cycles at pc=5 with ack -> outputs frozen, state HOLD, pc=6; stall release -> instr@5 delivered once, next fetch addr 6.
REQ-032 BrZ=1, Z=1, br_target=0x40 while ack=1 -> flush_out=1 same cycle, valid_out=0 next, next imem_addr=0x40.
REQ-033 jump_mem=1, mem_target=0x80 while ack pending -> DRAIN; late ack data discarded; next request at 0x80.
REQ-034 BrN=1, N=0 -> no redirect, sequential fetch continues; redirect with stall=1 -> valid_out=0 anyway.
REQ-035 RESET_PC=32'hFFFF_FFFF -> second fetch address 32'h0; rst asserted mid-DRAIN -> FETCH at RESET_PC.
